// File: rtl/flit_link_arbiter.sv
// Round-robin flit link arbiter with packet locking and one registered output stage.
// Optional owner-stall watchdog: define FLIT_ARB_WATCHDOG_EN.
module flit_link_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int WDT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0][127:0]  req_flit,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       out_valid,
  output logic [127:0]               out_flit,
  input  logic                       out_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       locked,
  output logic [31:0]                err
);
  localparam int IW = $clog2(NUM_REQ);

  typedef logic [127:0] flit_t;
  localparam logic [3:0]  FT_HEAD = 4'd0, FT_TAIL = 4'd2, FT_NOPE = 4'd3;
  localparam logic [31:0] NO_ERROR = 32'h0, TX_NOT_REACHABLE = 32'h2;

  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nxt;

  logic [IW-1:0] rr_ptr, win_idx, sel_idx;
  logic [IW:0]   cand;
  logic          win_vld, load, accept, wdt_fire;
  logic [3:0]    ftype;

  assign load   = !out_valid || out_ready;
  assign locked = (state == LOCKED);

  function automatic logic [IW-1:0] rr_next(input logic [IW-1:0] i);
    return (i == IW'(NUM_REQ-1)) ? '0 : i + 1'b1;
  endfunction

  // First valid requester at or after rr_ptr, wrapping explicitly at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = rr_ptr;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_vld && req_valid[cand[IW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    sel_idx   = grant_idx;
    if (!rst) begin
      if (state == IDLE) begin
        if (win_vld) begin
          sel_idx            = win_idx;
          req_ready[win_idx] = load;
        end
      end else begin
        req_ready[grant_idx] = load;
      end
    end
    accept = req_valid[sel_idx] && req_ready[sel_idx];
    ftype  = req_flit[sel_idx][123:120];
    if (ftype > FT_NOPE) ftype = FT_NOPE;
    if (accept) begin
      case (state)
        IDLE:    if (ftype == FT_HEAD) state_nxt = LOCKED;
        LOCKED:  if (ftype == FT_TAIL) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
    if (wdt_fire) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_flit  <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_flit  <= flit_t'(req_flit[sel_idx]);
        grant_idx <= sel_idx;
        if (state == IDLE) rr_ptr <= rr_next(sel_idx);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (wdt_fire) rr_ptr <= rr_next(grant_idx);
    end
  end

`ifdef FLIT_ARB_WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES) + 1;
  logic [WW-1:0] wdt_cnt;
  logic          stall;

  // Only an absent owner counts; downstream backpressure leaves the count alone.
  assign stall    = (state == LOCKED) && !req_valid[grant_idx] && load;
  assign wdt_fire = stall && (wdt_cnt == WW'(WDT_CYCLES-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_cnt <= '0;
      err     <= NO_ERROR;
    end else begin
      err <= wdt_fire ? TX_NOT_REACHABLE : NO_ERROR;
      if (state != LOCKED || accept || wdt_fire) wdt_cnt <= '0;
      else if (stall) wdt_cnt <= wdt_cnt + 1'b1;
    end
  end
`else
  assign wdt_fire = 1'b0;
  assign err      = NO_ERROR;
`endif
endmodule

// File: tb/tb_flit_link_arbiter.sv
// Bench for flit_link_arbiter: vector table, directed corner sequences, random traffic vs model.
module tb_flit_link_arbiter;
  localparam int N = 4;
  localparam int WDT = 16;
  localparam logic [3:0] HEAD = 4'd0, BODY = 4'd1, TAIL = 4'd2, NOPE = 4'd3;

  logic               clk = 1'b0, rst = 1'b1;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0][127:0] req_flit = '0;
  logic [N-1:0]       req_ready;
  logic               out_valid, out_ready = 1'b1, locked;
  logic [127:0]       out_flit;
  logic [1:0]         grant_idx;
  logic [31:0]        err;

  flit_link_arbiter #(.NUM_REQ(N), .WDT_CYCLES(WDT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_flit(req_flit),
    .req_ready(req_ready), .out_valid(out_valid), .out_flit(out_flit),
    .out_ready(out_ready), .grant_idx(grant_idx), .locked(locked), .err(err));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  // Reference state: what the link should look like, from the arbitration rules.
  logic         m_ov;
  logic [127:0] m_of;
  int           m_grant, m_rr, m_stall;
  logic         m_lock;
  logic [31:0]  m_err;
  logic [3:0]   smp_rdy;

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_ov = 0; m_of = '0; m_grant = 0; m_rr = 0; m_stall = 0; m_lock = 0; m_err = '0;
  endtask

  function automatic logic [127:0] mk(input int r, input logic [3:0] t, input int s);
    return {4'h0, t, 88'h0, 16'(r), 16'(s)};
  endfunction

  // One clock: check ready against the model, clock, advance model, check outputs.
  task automatic cyc();
    logic [3:0] er, acc, t;
    logic ld;
    int w;
    #1;
    ld = !m_ov || out_ready;
    er = '0;
    w = -1;
    if (m_lock) er[m_grant] = ld;
    else begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
      if (w >= 0) er[w] = ld;
    end
    smp_rdy = req_ready;
    chk("req_ready", req_ready, er);
    @(posedge clk);
    acc = er & req_valid;
    m_err = '0;
    if (acc != 0) begin
      for (int k = 0; k < N; k++) if (acc[k]) w = k;
      t = req_flit[w][123:120];
      if (t > NOPE) t = NOPE;
      m_ov = 1; m_of = req_flit[w]; m_grant = w; m_stall = 0;
      if (!m_lock) begin
        m_rr = (w + 1) % N;
        if (t == HEAD) m_lock = 1;
      end else if (t == TAIL) m_lock = 0;
    end else begin
      if (ld) m_ov = 0;
`ifdef FLIT_ARB_WATCHDOG_EN
      if (m_lock && !req_valid[m_grant] && ld) begin
        m_stall++;
        if (m_stall == WDT) begin
          m_lock = 0; m_err = 32'h2; m_rr = (m_grant + 1) % N; m_stall = 0;
        end
      end
`endif
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_flit", out_flit, m_of);
    chk("grant_idx", grant_idx, m_grant);
    chk("locked", locked, m_lock);
    chk("err", err, m_err);
  endtask

  typedef struct {
    logic [3:0]  vld;
    logic [15:0] ft;
    logic [3:0]  rdy;
    logic [1:0]  gnt;
    logic        lck;
  } tv_t;
  tv_t tv [19];

  initial begin
    logic [127:0] held;
    tv[0]  = '{4'hF, 16'h3333, 4'b0001, 2'd0, 1'b0};
    tv[1]  = '{4'hF, 16'h3333, 4'b0010, 2'd1, 1'b0};
    tv[2]  = '{4'hF, 16'h3333, 4'b0100, 2'd2, 1'b0};
    tv[3]  = '{4'hF, 16'h3333, 4'b1000, 2'd3, 1'b0};
    tv[4]  = '{4'hF, 16'h3333, 4'b0001, 2'd0, 1'b0};
    tv[5]  = '{4'h7, 16'h3303, 4'b0010, 2'd1, 1'b1};
    tv[6]  = '{4'h7, 16'h3313, 4'b0010, 2'd1, 1'b1};
    tv[7]  = '{4'h7, 16'h3323, 4'b0010, 2'd1, 1'b0};
    tv[8]  = '{4'h5, 16'h3333, 4'b0100, 2'd2, 1'b0};
    tv[9]  = '{4'h1, 16'h3331, 4'b0001, 2'd0, 1'b0};
    tv[10] = '{4'h3, 16'h3333, 4'b0010, 2'd1, 1'b0};
    tv[11] = '{4'h4, 16'h3F33, 4'b0100, 2'd2, 1'b0};
    tv[12] = '{4'h0, 16'h3333, 4'b0000, 2'd2, 1'b0};
    tv[13] = '{4'h9, 16'h3333, 4'b1000, 2'd3, 1'b0};
    tv[14] = '{4'h1, 16'h3330, 4'b0001, 2'd0, 1'b1};
    tv[15] = '{4'h3, 16'h3330, 4'b0001, 2'd0, 1'b1};
    tv[16] = '{4'h3, 16'h3333, 4'b0001, 2'd0, 1'b1};
    tv[17] = '{4'h3, 16'h3332, 4'b0001, 2'd0, 1'b0};
    tv[18] = '{4'h3, 16'h3333, 4'b0010, 2'd1, 1'b0};

    // Reset state, with requesters already valid to show ready is held low.
    model_reset();
    req_valid = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 4'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_flit", out_flit, 128'h0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_grant", grant_idx, 2'd0);
    chk("rst_err", err, 32'h0);
    rst = 1'b0;

    foreach (tv[i]) begin
      req_valid = tv[i].vld;
      for (int r = 0; r < N; r++) req_flit[r] = mk(r, tv[i].ft[4*r +: 4], i);
      cyc();
      chk("tv_ready", smp_rdy, tv[i].rdy);
      chk("tv_grant", grant_idx, tv[i].gnt);
      chk("tv_locked", locked, tv[i].lck);
    end

    // Backpressure: the held flit must stay put and nobody may be accepted.
    req_valid = 4'hF;
    for (int r = 0; r < N; r++) req_flit[r] = mk(r, NOPE, 100);
    cyc();
    held = mk(2, NOPE, 100);
    chk("bp_load", out_flit, held);
    out_ready = 1'b0;
    repeat (5) begin
      cyc();
      chk("bp_ready", smp_rdy, 4'b0);
      chk("bp_hold", out_flit, held);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_resume_ready", smp_rdy, 4'b1000);
    chk("bp_resume_flit", out_flit, mk(3, NOPE, 100));

    // Reset mid-packet, after req3 HEAD.
    req_valid = 4'b1000;
    req_flit[3] = mk(3, HEAD, 200);
    cyc();
    chk("mid_locked", locked, 1'b1);
    rst = 1'b1;
    #2;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_grant", grant_idx, 2'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    req_valid = 4'b1001;
    for (int r = 0; r < N; r++) req_flit[r] = mk(r, NOPE, 300);
    cyc();
    chk("mid_rst_winner", smp_rdy, 4'b0001);

    // Owner goes quiet after its HEAD.
    req_valid = 4'b0100;
    req_flit[2] = mk(2, HEAD, 400);
    cyc();
    req_valid = 4'b1011;
    for (int k = 1; k <= 20; k++) begin
      cyc();
`ifdef FLIT_ARB_WATCHDOG_EN
      if (k == 16) begin
        chk("wdt_err", err, 32'h2);
        chk("wdt_unlock", locked, 1'b0);
      end else if (k == 17) begin
        chk("wdt_next_grant", grant_idx, 2'd3);
        chk("wdt_err_clear", err, 32'h0);
      end else if (k < 16) chk("wdt_hold", locked, 1'b1);
`else
      chk("lock_hold", locked, 1'b1);
      chk("lock_ready", smp_rdy, 4'b0100);
`endif
    end

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      req_valid = 4'($urandom);
      for (int r = 0; r < N; r++) begin
        req_flit[r] = {$urandom, $urandom, $urandom, $urandom};
        req_flit[r][123:120] = 4'($urandom_range(0, 5));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/flit_link_arbiter.md
Name: flit_link_arbiter

Overview:
- Shares one outgoing flit link (128-bit flit_t) between NUM_REQ requesters, e.g. the local injection queue and router input buffers.
- Round-robin arbitration with packet locking: once a HEAD flit wins, the owner keeps the link until its TAIL flit is accepted, so packets never interleave.
- One registered output stage with valid/ready on all sides; feeds the UART TX framer or the next router stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WDT_CYCLES, 1024, watchdog limit: owner-stall cycles before a lock is forcibly released (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester flit valid.
- req_flit  in  NUM_REQ x 128  per-requester flit_t.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- out_valid  out  1  output flit valid (registered).
- out_flit  out  128  output flit_t (registered).
- out_ready  in  1  downstream accept.
- grant_idx  out  $clog2(NUM_REQ)  current or last owner index.
- locked  out  1  high while a packet owns the link.
- err  out  32  signal_t; pulses TX_NOT_REACHABLE for one cycle on watchdog release, otherwise NO_ERROR.

Behaviour:
- Reset (async): out_valid=0, out_flit=0, req_ready=0, locked=0, grant_idx=0, rr pointer=0, err=NO_ERROR, watchdog=0.
- Stage free condition: `load = !out_valid || out_ready`.
- FSM states: IDLE, LOCKED.
- IDLE:
  - Winner is the first valid requester searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[winner] = load; no other ready is high.
  - On acceptance (valid && ready), the flit is registered into the output stage, grant_idx <= winner, and rr_ptr <= winner+1 (mod NUM_REQ).
  - Accepted flittype HEAD -> go to LOCKED, locked <= 1.
  - Accepted BODY, TAIL or NOPE -> treated as single-beat; stay in IDLE.
- LOCKED:
  - Only req_ready[grant_idx] = load; all other requesters are held off even if valid.
  - Accepted TAIL -> go to IDLE, locked <= 0.
  - Accepted HEAD or BODY -> stay in LOCKED. A second HEAD does not re-arbitrate.
  - Accepted NOPE -> passed through, stay in LOCKED.
- Latency: an accepted flit appears on out_flit the next cycle.
- Throughput: 1 flit/cycle while out_ready=1.
- Output hold: out_flit is stable while out_valid && !out_ready.
- Flittype is decoded from bits [123:120]. Values above NOPE are treated as NOPE. The flit is never modified; the checksum passes through untouched.
- Boundaries:
  - No valid requester in IDLE: no acceptance; rr_ptr unchanged.
  - Backpressure (out_ready=0 with out_valid=1): all req_ready=0 and state is frozen.
  - Simultaneous output drain and new acceptance in the same cycle is allowed: the register is overwritten.
  - TAIL acceptance and IDLE re-arbitration never occur in the same cycle. A new winner is evaluated in the cycle after the TAIL.
  - NUM_REQ not a power of two: rr_ptr wraps explicitly from NUM_REQ-1 to 0.
  - Reset mid-packet: lock is dropped, the output flit is discarded, and arbitration restarts at requester 0.

Optional Feature:
- Macro: FLIT_ARB_WATCHDOG_EN.
- Defined:
  - In LOCKED, a counter increments each cycle the owner's req_valid=0 and clears on any owner acceptance.
  - When the count reaches WDT_CYCLES-1: go to IDLE, locked <= 0, err = TX_NOT_REACHABLE for exactly one cycle, rr_ptr <= grant_idx+1.
  - Downstream backpressure does not count toward the watchdog.
- Undefined:
  - No counter is built; the lock is held indefinitely.
  - err is tied to NO_ERROR.

Test Plan:
- Reset then all four req_valid=1 with NOPE flits, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; each flit appears on out_flit one cycle after its grant.
- Req1 sends HEAD, BODY, TAIL while req0 and req2 are continuously valid -> output order is 1H,1B,1T with no interleaving; locked=1 for 3 accepted beats; the next grant is 2.
- out_ready=0 for 5 cycles with out_valid=1 -> out_flit is unchanged and all req_ready=0; on out_ready=1 the flit drains and arbitration resumes in the same cycle.
- Async rst asserted mid-packet (after req3 HEAD) -> out_valid=0 and locked=0 immediately; after release, req0 and req3 both valid -> req0 wins.
- With FLIT_ARB_WATCHDOG_EN and WDT_CYCLES=16: req2 sends HEAD, then req_valid[2]=0 -> at the 16th stall cycle err=32'h2 for one cycle, locked=0, and req3 is granted next.
- Single requester (req0) sends BODY while IDLE -> passed single-beat, locked stays 0, and req1 can win the following cycle.
